// File: rtl/iccm_arbiter.sv
// Shares the ICCM request port between instruction fetch and the program-load port,
// sequencing LOAD/DRAIN/RUN/QUIESCE and holding the core in reset outside RUN.
module iccm_arbiter #(
    parameter int AddrW    = 12,
    parameter int DataW    = 32,
    parameter int Depth    = 2,
    parameter bit BootLoad = 1'b1
) (
    input  logic             clk_i,
    input  logic             rst_ni,
    input  logic             fetch_req_i,
    input  logic [AddrW-1:0] fetch_addr_i,
    output logic             fetch_gnt_o,
    output logic             fetch_rvalid_o,
    output logic [DataW-1:0] fetch_rdata_o,
    input  logic             prog_req_i,
    input  logic             prog_we_i,
    input  logic [AddrW-1:0] prog_addr_i,
    input  logic [DataW-1:0] prog_wdata_i,
    output logic             prog_gnt_o,
    output logic             prog_rvalid_o,
    output logic [DataW-1:0] prog_rdata_o,
    input  logic             boot_done_i,
    input  logic             reload_i,
    output logic             mem_req_o,
    output logic             mem_we_o,
    output logic [AddrW-1:0] mem_addr_o,
    output logic [DataW-1:0] mem_wdata_o,
    input  logic [DataW-1:0] mem_rdata_i,
    input  logic             mem_rvalid_i,
    output logic             core_rst_no,
    output logic             busy_o,
    output logic             err_o
);

    localparam int PtrW = (Depth > 1) ? $clog2(Depth) : 1;
    localparam int CntW = $clog2(Depth + 1);
    localparam logic [CntW-1:0] DepthC  = CntW'(Depth);
    localparam logic [PtrW-1:0] LastPtr = PtrW'(Depth - 1);

    typedef enum logic [1:0] {S_LOAD, S_DRAIN, S_RUN, S_QUIESCE} state_t;
    localparam state_t ResetState = BootLoad ? S_LOAD : S_RUN;

    state_t          r_state, w_state_nxt;
    logic [CntW-1:0] r_count, w_count_nxt;
    logic [PtrW-1:0] r_wr_ptr, r_rd_ptr;
    logic [Depth-1:0] r_tag_prog, r_tag_we;
    logic            r_last_prog;
    logic            r_err;
    logic            r_core_rst_n;

    logic w_pop, w_room, w_fetch_ok, w_prog_ok, w_fetch_gnt, w_prog_gnt, w_push;
    logic w_head_prog, w_head_we;

    // Outputs are gated by rst_ni so they read zero during an async reset.
    assign w_pop       = rst_ni & mem_rvalid_i & (r_count != '0);
    assign w_room      = (r_count < DepthC) | w_pop;
    assign w_fetch_ok  = rst_ni & fetch_req_i & (r_state == S_RUN) & w_room;
    assign w_prog_ok   = rst_ni & prog_req_i & ((r_state == S_LOAD) | (r_state == S_RUN)) & w_room;
    assign w_fetch_gnt = w_fetch_ok & (~w_prog_ok | r_last_prog);
    assign w_prog_gnt  = w_prog_ok & (~w_fetch_ok | ~r_last_prog);
    assign w_push      = w_fetch_gnt | w_prog_gnt;

    assign w_head_prog = r_tag_prog[r_rd_ptr];
    assign w_head_we   = r_tag_we[r_rd_ptr];

    always_comb begin
        w_count_nxt = r_count;
        if (w_push && !w_pop)
            w_count_nxt = r_count + CntW'(1);
        else if (!w_push && w_pop)
            w_count_nxt = r_count - CntW'(1);
    end

    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            S_LOAD:    if (boot_done_i)          w_state_nxt = S_DRAIN;
            S_DRAIN:   if (w_count_nxt == '0)    w_state_nxt = S_RUN;
            S_RUN:     if (reload_i)             w_state_nxt = S_QUIESCE;
            S_QUIESCE: if (w_count_nxt == '0)    w_state_nxt = S_LOAD;
            default:                             w_state_nxt = ResetState;
        endcase
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            r_state      <= ResetState;
            r_core_rst_n <= ~BootLoad;
        end else begin
            r_state      <= w_state_nxt;
            r_core_rst_n <= (w_state_nxt == S_RUN);
        end
    end

    // Tag FIFO: one entry per accepted request, carrying source and write flag.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            r_count     <= '0;
            r_wr_ptr    <= '0;
            r_rd_ptr    <= '0;
            r_tag_prog  <= '0;
            r_tag_we    <= '0;
            r_last_prog <= 1'b1;
            r_err       <= 1'b0;
        end else begin
            r_count <= w_count_nxt;
            if (w_push) begin
                r_tag_prog[r_wr_ptr] <= w_prog_gnt;
                r_tag_we[r_wr_ptr]   <= w_prog_gnt & prog_we_i;
                r_wr_ptr             <= (r_wr_ptr == LastPtr) ? '0 : r_wr_ptr + PtrW'(1);
                r_last_prog          <= w_prog_gnt;
            end
            if (w_pop)
                r_rd_ptr <= (r_rd_ptr == LastPtr) ? '0 : r_rd_ptr + PtrW'(1);
            if (mem_rvalid_i && (r_count == '0))
                r_err <= 1'b1;
        end
    end

    assign fetch_gnt_o    = w_fetch_gnt;
    assign prog_gnt_o     = w_prog_gnt;
    assign mem_req_o      = w_push;
    assign mem_we_o       = w_prog_gnt & prog_we_i;
    assign mem_addr_o     = w_prog_gnt ? prog_addr_i : (w_fetch_gnt ? fetch_addr_i : '0);
    assign mem_wdata_o    = w_prog_gnt ? prog_wdata_i : '0;

    assign fetch_rvalid_o = w_pop & ~w_head_prog;
    assign fetch_rdata_o  = fetch_rvalid_o ? mem_rdata_i : '0;
    assign prog_rvalid_o  = w_pop & w_head_prog;
    assign prog_rdata_o   = (prog_rvalid_o && !w_head_we) ? mem_rdata_i : '0;

    assign core_rst_no    = r_core_rst_n;
    assign busy_o         = (r_count != '0);
    assign err_o          = r_err;

endmodule

// File: tb/tb_iccm_arbiter.sv
// Directed bench for iccm_arbiter: a behavioural memory answers one cycle after each request
// and a scoreboard monitor checks every routed response against queued expectations.
module tb_iccm_arbiter;

    logic        clk_i = 1'b0;
    logic        rst_ni = 1'b0;
    logic        fetch_req_i = 1'b0;
    logic [11:0] fetch_addr_i = '0;
    logic        fetch_gnt_o, fetch_rvalid_o;
    logic [31:0] fetch_rdata_o;
    logic        prog_req_i = 1'b0, prog_we_i = 1'b0;
    logic [11:0] prog_addr_i = '0;
    logic [31:0] prog_wdata_i = '0;
    logic        prog_gnt_o, prog_rvalid_o;
    logic [31:0] prog_rdata_o;
    logic        boot_done_i = 1'b0, reload_i = 1'b0;
    logic        mem_req_o, mem_we_o;
    logic [11:0] mem_addr_o;
    logic [31:0] mem_wdata_o, mem_rdata_i;
    logic        mem_rvalid_i;
    logic        core_rst_no, busy_o, err_o;

    logic        mdl_rv = 1'b0, inj_rv = 1'b0, hold = 1'b0;
    logic [31:0] mdl_rd = '0;
    logic [31:0] mem [0:4095];
    logic [31:0] mq[$];
    logic [31:0] exp_f[$], exp_p[$];
    int          n_cmp = 0, n_err = 0;

    assign mem_rvalid_i = mdl_rv | inj_rv;
    assign mem_rdata_i  = inj_rv ? 32'h0000_0BAD : mdl_rd;

    iccm_arbiter dut (
        .clk_i(clk_i), .rst_ni(rst_ni),
        .fetch_req_i(fetch_req_i), .fetch_addr_i(fetch_addr_i), .fetch_gnt_o(fetch_gnt_o),
        .fetch_rvalid_o(fetch_rvalid_o), .fetch_rdata_o(fetch_rdata_o),
        .prog_req_i(prog_req_i), .prog_we_i(prog_we_i), .prog_addr_i(prog_addr_i),
        .prog_wdata_i(prog_wdata_i), .prog_gnt_o(prog_gnt_o), .prog_rvalid_o(prog_rvalid_o),
        .prog_rdata_o(prog_rdata_o), .boot_done_i(boot_done_i), .reload_i(reload_i),
        .mem_req_o(mem_req_o), .mem_we_o(mem_we_o), .mem_addr_o(mem_addr_o),
        .mem_wdata_o(mem_wdata_o), .mem_rdata_i(mem_rdata_i), .mem_rvalid_i(mem_rvalid_i),
        .core_rst_no(core_rst_no), .busy_o(busy_o), .err_o(err_o)
    );

    always #5 clk_i = ~clk_i;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %h expected %h", nm, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk_i);
        #1;
    endtask

    task automatic gnt_chk(input string nm, input logic ef, input logic ep);
        chk({nm, "_fetch_gnt"}, fetch_gnt_o, ef);
        chk({nm, "_prog_gnt"}, prog_gnt_o, ep);
    endtask

    // Memory model: samples requests mid-cycle, answers in order one cycle later
    // unless held off. Writes return garbage rdata so write-ack zeroing is visible.
    initial begin
        for (int a = 0; a < 4096; a++) mem[a] = '0;
        forever begin
            @(negedge clk_i);
            if (!rst_ni) begin
                mq.delete();
            end else begin
                if (mdl_rv) void'(mq.pop_front());
                if (mem_req_o) begin
                    if (mem_we_o) mem[mem_addr_o] = mem_wdata_o;
                    mq.push_back(mem_we_o ? 32'hFFFF_FFFF : mem[mem_addr_o]);
                end
            end
            @(posedge clk_i);
            #1;
            if (!rst_ni || hold || mq.size() == 0) begin
                mdl_rv = 1'b0;
                mdl_rd = '0;
            end else begin
                mdl_rv = 1'b1;
                mdl_rd = mq[0];
            end
        end
    end

    // Scoreboard monitor.
    always @(negedge clk_i) begin
        if (rst_ni) begin
            if (fetch_rvalid_o) begin
                if (exp_f.size() == 0) begin
                    n_cmp++; n_err++;
                    $display("FAIL fetch_unexpected: got rdata %h expected no response", fetch_rdata_o);
                end else begin
                    chk("fetch_rdata", fetch_rdata_o, exp_f.pop_front());
                end
                chk("prog_rdata_nontarget", prog_rdata_o, 32'h0);
            end
            if (prog_rvalid_o) begin
                if (exp_p.size() == 0) begin
                    n_cmp++; n_err++;
                    $display("FAIL prog_unexpected: got rdata %h expected no response", prog_rdata_o);
                end else begin
                    chk("prog_rdata", prog_rdata_o, exp_p.pop_front());
                end
                chk("fetch_rdata_nontarget", fetch_rdata_o, 32'h0);
            end
        end
    end

    initial begin
        #150000;
        $display("FAIL watchdog: simulation did not end, expected completion");
        $fatal(1);
    end

    initial begin
        // Reset state, with a request pending that must stay blocked.
        prog_req_i = 1'b1;
        #3;
        chk("rst_prog_gnt", prog_gnt_o, 0);
        chk("rst_mem_req", mem_req_o, 0);
        chk("rst_core", core_rst_no, 0);
        chk("rst_busy", busy_o, 0);
        chk("rst_err", err_o, 0);
        prog_req_i = 1'b0;
        repeat (2) @(posedge clk_i);
        #1 rst_ni = 1'b1;

        // Boot load with fetch held requesting.
        for (int i = 0; i < 4; i++) begin
            if (i != 0) tick();
            prog_req_i = 1'b1; prog_we_i = 1'b1; prog_addr_i = 12'(i); prog_wdata_i = 32'h13;
            fetch_req_i = 1'b1; fetch_addr_i = 12'h3;
            #3;
            gnt_chk("load", 1'b0, 1'b1);
            chk("load_mem_addr", mem_addr_o, i);
            chk("load_mem_we", mem_we_o, 1);
            chk("load_core", core_rst_no, 0);
            exp_p.push_back(32'h0);
        end
        tick(); prog_req_i = 1'b0; boot_done_i = 1'b1;
        #3; gnt_chk("bootdone", 1'b0, 1'b0); chk("bootdone_mem_req", mem_req_o, 0);
        tick(); boot_done_i = 1'b0;
        #3; gnt_chk("drain", 1'b0, 1'b0); chk("drain_core", core_rst_no, 0); chk("drain_busy", busy_o, 0);

        tick(); fetch_addr_i = 12'h2;
        #3; gnt_chk("run_fetch", 1'b1, 1'b0);
        chk("run_core", core_rst_no, 1); chk("run_fetch_addr", mem_addr_o, 2); chk("run_fetch_we", mem_we_o, 0);
        exp_f.push_back(32'h13);

        tick(); fetch_req_i = 1'b0;
        prog_req_i = 1'b1; prog_we_i = 1'b1; prog_addr_i = 12'h5; prog_wdata_i = 32'hA5A5_0005;
        #3; gnt_chk("run_wr5", 1'b0, 1'b1); chk("run_busy", busy_o, 1);
        exp_p.push_back(32'h0);
        tick(); prog_addr_i = 12'h6; prog_wdata_i = 32'h5A5A_0006;
        #3; gnt_chk("run_wr6", 1'b0, 1'b1); chk("run_wr_data", mem_wdata_o, 32'h5A5A_0006);
        exp_p.push_back(32'h0);
        tick(); prog_we_i = 1'b0; prog_addr_i = 12'h5;
        #3; gnt_chk("run_rd5", 1'b0, 1'b1); chk("run_rd_we", mem_we_o, 0);
        exp_p.push_back(32'hA5A5_0005);

        // Round-robin: last winner was prog, so fetch wins the first tie.
        for (int i = 0; i < 4; i++) begin
            tick();
            fetch_req_i = 1'b1; fetch_addr_i = 12'h6;
            prog_req_i = 1'b1; prog_we_i = 1'b0; prog_addr_i = 12'h2;
            #3;
            if (i % 2 == 0) begin
                gnt_chk("rr_fetch_turn", 1'b1, 1'b0);
                chk("rr_addr", mem_addr_o, 6);
                exp_f.push_back(32'h5A5A_0006);
            end else begin
                gnt_chk("rr_prog_turn", 1'b0, 1'b1);
                chk("rr_addr", mem_addr_o, 2);
                exp_p.push_back(32'h13);
            end
        end
        tick(); fetch_req_i = 1'b0; prog_req_i = 1'b0;
        #3; hold = 1'b1;

        // Backpressure: two slots, memory responses held off.
        tick(); fetch_req_i = 1'b1; fetch_addr_i = 12'h0;
        #3; gnt_chk("bp0", 1'b1, 1'b0); exp_f.push_back(32'h13);
        tick(); fetch_addr_i = 12'h1;
        #3; gnt_chk("bp1", 1'b1, 1'b0); exp_f.push_back(32'h13);
        tick(); fetch_addr_i = 12'h2;
        #3; gnt_chk("bp_full_a", 1'b0, 1'b0); chk("bp_full_mem_req", mem_req_o, 0);
        tick();
        #3; gnt_chk("bp_full_b", 1'b0, 1'b0); hold = 1'b0;
        tick();
        #3; gnt_chk("bp_pop_gnt", 1'b1, 1'b0); exp_f.push_back(32'h13); hold = 1'b1;
        tick(); fetch_addr_i = 12'h3;
        #3; gnt_chk("bp_still_full", 1'b0, 1'b0); hold = 1'b0;
        tick();
        #3; gnt_chk("bp_pop_gnt2", 1'b1, 1'b0); exp_f.push_back(32'h13);
        tick(); fetch_req_i = 1'b0;
        tick();
        tick();
        #3; chk("bp_drained_busy", busy_o, 0); hold = 1'b1;

        // Reload with two outstanding requests.
        tick(); fetch_req_i = 1'b1; fetch_addr_i = 12'h5;
        #3; gnt_chk("rl_a", 1'b1, 1'b0); exp_f.push_back(32'hA5A5_0005);
        tick(); fetch_addr_i = 12'h6;
        #3; gnt_chk("rl_b", 1'b1, 1'b0); exp_f.push_back(32'h5A5A_0006);
        tick(); reload_i = 1'b1; fetch_addr_i = 12'h7;
        prog_req_i = 1'b1; prog_we_i = 1'b0; prog_addr_i = 12'h0;
        #3; gnt_chk("rl_trigger", 1'b0, 1'b0); chk("rl_trigger_core", core_rst_no, 1); hold = 1'b0;
        tick(); reload_i = 1'b0;
        #3; gnt_chk("quiesce_a", 1'b0, 1'b0); chk("quiesce_core", core_rst_no, 0);
        tick();
        #3; gnt_chk("quiesce_b", 1'b0, 1'b0);
        tick();
        #3; gnt_chk("reload_load", 1'b0, 1'b1); chk("reload_core", core_rst_no, 0);
        exp_p.push_back(32'h13);
        tick(); fetch_req_i = 1'b0; prog_req_i = 1'b0;

        // Stray response with an empty FIFO.
        tick(); inj_rv = 1'b1;
        #3; chk("stray_fetch_rv", fetch_rvalid_o, 0); chk("stray_prog_rv", prog_rvalid_o, 0);
        chk("stray_err_pre", err_o, 0);
        tick(); inj_rv = 1'b0;
        #3; chk("stray_err", err_o, 1);
        tick();
        #3; chk("stray_err_sticky", err_o, 1);

        // Async reset in the middle of a load burst.
        tick(); prog_req_i = 1'b1; prog_we_i = 1'b1; prog_addr_i = 12'h8; prog_wdata_i = 32'h1111_1111;
        #3; gnt_chk("burst_a", 1'b0, 1'b1); exp_p.push_back(32'h0);
        tick(); prog_addr_i = 12'h9; fetch_req_i = 1'b1; fetch_addr_i = 12'h3;
        #3; gnt_chk("burst_b", 1'b0, 1'b1); chk("burst_busy", busy_o, 1);
        rst_ni = 1'b0;
        exp_f.delete(); exp_p.delete();
        #1;
        gnt_chk("arst", 1'b0, 1'b0);
        chk("arst_mem_req", mem_req_o, 0);
        chk("arst_mem_we", mem_we_o, 0);
        chk("arst_mem_addr", mem_addr_o, 0);
        chk("arst_mem_wdata", mem_wdata_o, 0);
        chk("arst_err", err_o, 0);
        chk("arst_busy", busy_o, 0);
        chk("arst_core", core_rst_no, 0);
        chk("arst_prog_rv", prog_rvalid_o, 0);
        chk("arst_prog_rdata", prog_rdata_o, 0);
        tick();
        tick();
        prog_we_i = 1'b0; prog_addr_i = 12'h2;
        tick(); rst_ni = 1'b1;
        #3; gnt_chk("post_rst_load", 1'b0, 1'b1);
        chk("post_rst_err", err_o, 0); chk("post_rst_core", core_rst_no, 0);
        exp_p.push_back(32'h13);
        tick(); prog_req_i = 1'b0; fetch_req_i = 1'b0;
        tick();
        tick();
        #3; chk("scoreboard_drained", 32'(exp_f.size() + exp_p.size()), 0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule

// File: doc/iccm_arbiter.md
# iccm_arbiter

Sequences and shares the 12-bit-address instruction memory (ICCM) between two requesters: the instruction-fetch path (output of the ICCM TL-UL SRAM adapter) and a program-load port (boot loader / debug reprogramming) that writes and reads the memory. It owns the ICCM's single request port and its load/run mode. It holds the core in reset while the memory is being loaded. Sits between `tlul_sram_adapter`, the boot-load engine, `instr_mem_top` and `brq_core_top` reset.

## Interface
Parameters:
- `AddrW`, 12, word address width.
- `DataW`, 32, data width.
- `Depth`, 2, max outstanding memory requests (tag FIFO depth, ≥1).
- `BootLoad`, 1'b1, reset state: 1 = LOAD, 0 = RUN.

Ports:
- `clk_i` in 1, system clock.
- `rst_ni` in 1, reset; **asynchronous, active-low**. Single clock domain.
- `fetch_req_i` in 1, fetch read request (fetch never writes).
- `fetch_addr_i` in AddrW, fetch address.
- `fetch_gnt_o` out 1, fetch request accepted this cycle.
- `fetch_rvalid_o` out 1, fetch read data valid.
- `fetch_rdata_o` out DataW, fetch read data.
- `prog_req_i` in 1, program-port request.
- `prog_we_i` in 1, 1 = write.
- `prog_addr_i` in AddrW, program-port address.
- `prog_wdata_i` in DataW, program-port write data.
- `prog_gnt_o` out 1, program-port request accepted.
- `prog_rvalid_o` out 1, response (read data or write ack).
- `prog_rdata_o` out DataW, read data; 0 for write acks.
- `boot_done_i` in 1, pulse: loading complete.
- `reload_i` in 1, pulse: return to LOAD.
- `mem_req_o` out 1, memory request.
- `mem_we_o` out 1, memory write enable.
- `mem_addr_o` out AddrW, memory address.
- `mem_wdata_o` out DataW, memory write data.
- `mem_rdata_i` in DataW, memory read data.
- `mem_rvalid_i` in 1, one pulse per accepted request, in order.
- `core_rst_no` out 1, core reset, active-low.
- `busy_o` out 1, tag FIFO non-empty.
- `err_o` out 1, sticky: `mem_rvalid_i` received with an empty tag FIFO.

## Operation
- The FSM has four states: LOAD, DRAIN, RUN and QUIESCE.
  - LOAD: only `prog` is granted. `boot_done_i` moves the FSM to DRAIN.
  - DRAIN: no new grants. Moves to RUN when the FIFO is empty (may be the same cycle the FIFO empties).
  - RUN: both requesters are arbitrated. `reload_i` moves the FSM to QUIESCE.
  - QUIESCE: no new grants. Moves to LOAD when the FIFO is empty.
  - Pulses that arrive outside their active state are ignored.
- `core_rst_no` is registered: 1 in RUN only, 0 in all other states.
- Grant eligibility: the state permits the requester AND (count < Depth OR a pop occurs this cycle).
- RUN arbitration: round-robin on simultaneous requests. The pointer `last` records the most recent winner and the other requester wins next. `last` resets to prog, so fetch wins the first tie.
- Mux: `mem_*` carry the granted requester's fields. `mem_we_o` = `prog_we_i` when prog is granted, 0 when fetch is granted. `mem_req_o` = any grant.
- Tag FIFO: each grant pushes a 1-bit source ID; each `mem_rvalid_i` pops one entry. Push and pop in the same cycle keeps count unchanged.
- Response routing: on `mem_rvalid_i`, the FIFO head selects the target.
  - Fetch target: `fetch_rvalid_o` = 1, `fetch_rdata_o` = `mem_rdata_i`.
  - Prog target: `prog_rvalid_o` = 1; `prog_rdata_o` = `mem_rdata_i` for a read, 0 for a write (a we bit is stored with the tag).
  - Non-target rdata outputs are 0.
- Pop with an empty FIFO sets `err_o` (sticky until reset); no rvalid is forwarded.

## Timing
- Grants and the `mem_*` outputs are combinational from the requests, state and count: zero-cycle grant.
- Response routing is combinational from `mem_rvalid_i` and the FIFO head. The memory returns rvalid at cycle N+1 for a request at cycle N, so end-to-end latency is 1 cycle.
- Back-to-back grants every cycle are sustained with Depth ≥ 1, because a same-cycle pop frees a slot.
- Reset (async assert, synchronous deassert by the reset manager):
  - State = LOAD if BootLoad else RUN; `core_rst_no` = 0 if BootLoad else 1.
  - FIFO empty, `last` = prog, `err_o` = 0.
  - All gnt, rvalid and rdata outputs = 0; all `mem_*` outputs = 0.
- Reset mid-transaction discards all outstanding tags. Any later stray `mem_rvalid_i` sets `err_o`.
- State transitions take effect the cycle after the triggering input. Grants in the trigger cycle follow the old state.

## Test plan
- Boot load: BootLoad=1. Write 0x00000013 to addrs 0..3 via prog; `prog_rvalid_o` pulses 4× with rdata 0; `core_rst_no` stays 0. Pulse `boot_done_i` → DRAIN then RUN; `core_rst_no` = 1 one cycle after the FIFO empties.
- Fetch blocked in LOAD: `fetch_req_i` = 1 held in LOAD → `fetch_gnt_o` = 0 and `mem_req_o` driven by prog only. In RUN, fetch addr 0x002 → `fetch_rvalid_o` next cycle with the loaded data.
- Round-robin: both requesting continuously in RUN → grant order fetch, prog, fetch, prog. Each response is routed to the correct port with matching data.
- Backpressure: Depth=2, memory rvalid withheld 3 cycles → exactly 2 grants, then gnt = 0 until a pop. On the pop cycle a new grant is issued; count stays 2.
- Reload: `reload_i` in RUN with 2 outstanding → no new grants, both responses delivered, then LOAD with `core_rst_no` = 0.
- Error and reset: `mem_rvalid_i` pulse with an empty FIFO → `err_o` = 1 and sticky. Async `rst_ni` low mid-burst → all outputs are 0 immediately, state returns to LOAD, `err_o` clears.
